// File: rtl/bcd_countdown_timer_if.sv
// rtl/bcd_countdown_timer_if.sv - control/status bundle for the BCD countdown timer
// add30 exists only when TIMER_ADD30_EN is defined.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic                  tick;
  logic                  load;
  logic                  start;
  logic                  pause;
  logic                  cancel;
  logic [4*DIGITS-1:0]   digits_in;
  logic [4*DIGITS-1:0]   digits_out;
  logic [1:0]            state;
  logic                  running;
  logic                  zero;
  logic                  done;
  logic                  load_err;
`ifdef TIMER_ADD30_EN
  logic                  add30;
`endif

  modport master (
`ifdef TIMER_ADD30_EN
    output add30,
`endif
    output tick, load, start, pause, cancel, digits_in,
    input  digits_out, state, running, zero, done, load_err
  );

  modport slave (
`ifdef TIMER_ADD30_EN
    input  add30,
`endif
    input  tick, load, start, pause, cancel, digits_in,
    output digits_out, state, running, zero, done, load_err
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - mixed-radix BCD countdown timer with run/pause/done control
// Optional +30 s quick-add is enabled by defining TIMER_ADD30_EN.
module bcd_countdown_timer #(
  parameter int                DIGITS    = 4,
  parameter logic [DIGITS-1:0] MOD6_MASK = DIGITS'(4'b0010)
) (
  input  logic                 clk,
  input  logic                 clear_n,
  bcd_countdown_timer_if.slave bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, next_val, clamped, dec_val;
  logic         clamp_any, dec_zero, cnt_zero;
  logic         done_q, load_err_q;
  logic         do_load, do_pause, do_start, do_tick, do_add;

  function automatic logic [3:0] dmax(input int i);
    return MOD6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  assign cnt_zero = (cnt_q == '0);

  // A command that does not apply in the current state falls through to the next one.
  always_comb begin
    do_load  = bus.load && (state_q != S_RUN);
    do_pause = !do_load && bus.pause && (state_q == S_RUN);
    do_start = !do_load && !do_pause && bus.start && !cnt_zero &&
               ((state_q == S_IDLE) || (state_q == S_PAUSED));
    do_tick  = !do_load && !do_pause && !do_start && bus.tick && (state_q == S_RUN);
`ifdef TIMER_ADD30_EN
    do_add   = !do_load && !do_pause && !do_start && bus.add30 && (state_q != S_DONE);
`else
    do_add   = 1'b0;
`endif
  end

  always_comb begin
    logic       borrow;
    logic [3:0] d;
    clamped   = '0;
    clamp_any = 1'b0;
    dec_val   = '0;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = bus.digits_in[4*i +: 4];
      if (d > dmax(i)) begin
        clamped[4*i +: 4] = dmax(i);
        clamp_any         = 1'b1;
      end else begin
        clamped[4*i +: 4] = d;
      end
      d = cnt_q[4*i +: 4];
      if (!borrow) begin
        dec_val[4*i +: 4] = d;
      end else if (d == 4'd0) begin
        dec_val[4*i +: 4] = dmax(i);
      end else begin
        dec_val[4*i +: 4] = d - 4'd1;
        borrow            = 1'b0;
      end
    end
    dec_zero = (dec_val == '0);
  end

`ifdef TIMER_ADD30_EN
  logic [W-1:0] add_val;

  // Add 3 tens-of-seconds on top of the (possibly decremented) count; overflow saturates.
  always_comb begin
    logic         carry;
    logic [4:0]   sum;
    logic [W-1:0] base_val;
    base_val = do_tick ? dec_val : cnt_q;
    add_val  = '0;
    carry    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      sum = {1'b0, base_val[4*i +: 4]} + ((i == 1) ? 5'd3 : 5'd0) + {4'd0, carry};
      if (sum > {1'b0, dmax(i)}) begin
        sum   = sum - ({1'b0, dmax(i)} + 5'd1);
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      add_val[4*i +: 4] = sum[3:0];
    end
    if (carry) begin
      for (int i = 0; i < DIGITS; i++) add_val[4*i +: 4] = dmax(i);
    end
  end
`endif

  always_comb begin
    next_val = cnt_q;
    if (bus.cancel)   next_val = '0;
    else if (do_load) next_val = clamped;
`ifdef TIMER_ADD30_EN
    else if (do_add)  next_val = add_val;
`endif
    else if (do_tick) next_val = dec_val;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.cancel)     state_d = S_IDLE;
    else if (do_load)   state_d = (state_q == S_PAUSED) ? S_PAUSED : S_IDLE;
    else if (do_pause)  state_d = S_PAUSED;
    else if (do_start)  state_d = S_RUN;
    else if (do_add) begin
      if ((state_q == S_IDLE) && cnt_zero) state_d = S_RUN;
    end else if (do_tick && dec_zero) state_d = S_DONE;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q      <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= next_val;
      done_q     <= (state_q == S_RUN) && (state_d == S_DONE);
      load_err_q <= !bus.cancel && do_load && clamp_any;
    end
  end

  always_comb begin
    bus.state      = state_q;
    bus.running    = (state_q == S_RUN);
    bus.digits_out = cnt_q;
    bus.zero       = cnt_zero;
    bus.done       = done_q;
    bus.load_err   = load_err_q;
  end
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - randomized self-checking bench against an integer-seconds model
module tb_bcd_countdown_timer;
  localparam int         DIGITS = 4;
  localparam logic [3:0] MASK   = 4'b0010;

  logic clk     = 1'b0;
  logic clear_n = 1'b1;

  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus ();

  bcd_countdown_timer #(.DIGITS(DIGITS), .MOD6_MASK(MASK)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;

  // Model: count held as total seconds, state as 0 idle / 1 run / 2 paused / 3 done.
  int  m_val  = 0;
  int  m_st   = 0;
  bit  m_done = 1'b0;
  bit  m_lerr = 1'b0;
  int  m_old;
  bit  m_t, m_a;
  logic [15:0] din_r;

  function automatic int radix(input int i);
    return MASK[i] ? 6 : 10;
  endfunction

  function automatic int max_val();
    int p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * radix(i);
    return p - 1;
  endfunction

  function automatic logic [15:0] to_dig(input int v);
    logic [15:0] d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d[4*i +: 4] = 4'(v % radix(i));
      v = v / radix(i);
    end
    return d;
  endfunction

  function automatic int clamp_val(input logic [15:0] d, output bit any);
    int v = 0;
    int w = 1;
    int x;
    any = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      x = int'(d[4*i +: 4]);
      if (x > radix(i) - 1) begin
        x   = radix(i) - 1;
        any = 1'b1;
      end
      v = v + x * w;
      w = w * radix(i);
    end
    return v;
  endfunction

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m_val = 0; m_st = 0; m_done = 1'b0; m_lerr = 1'b0;
    end else begin
      m_done = 1'b0;
      m_lerr = 1'b0;
      if (bus.cancel) begin
        m_val = 0; m_st = 0;
      end else if (bus.load && m_st != 1) begin
        m_val = clamp_val(bus.digits_in, m_lerr);
        m_st  = (m_st == 2) ? 2 : 0;
      end else if (bus.pause && m_st == 1) begin
        m_st = 2;
      end else if (bus.start && (m_st == 0 || m_st == 2) && m_val != 0) begin
        m_st = 1;
      end else begin
        m_old = m_val;
        m_t   = bus.tick && m_st == 1;
`ifdef TIMER_ADD30_EN
        m_a   = bus.add30 && m_st != 3;
`else
        m_a   = 1'b0;
`endif
        if (m_t) m_val = m_val - 1;
        if (m_a) m_val = (m_val + 30 > max_val()) ? max_val() : m_val + 30;
        if (m_t && !m_a && m_val == 0) begin
          m_st = 3; m_done = 1'b1;
        end
        if (m_a && m_st == 0 && m_old == 0) m_st = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("digits_out", 32'(bus.digits_out), 32'(to_dig(m_val)));
      chk("state",      32'(bus.state),      32'(m_st));
      chk("running",    32'(bus.running),    32'(m_st == 1));
      chk("zero",       32'(bus.zero),       32'(m_val == 0));
      chk("done",       32'(bus.done),       32'(m_done));
      chk("load_err",   32'(bus.load_err),   32'(m_lerr));
    end
  end

  task automatic expect_dig(input string name, input logic [15:0] exp);
    chk(name, 32'(bus.digits_out), 32'(exp));
    chk({name, "_model"}, 32'(to_dig(m_val)), 32'(exp));
  endtask

  task automatic drive(input bit tk, ld, st, ps, cn, input logic [15:0] din);
    bus.tick = tk; bus.load = ld; bus.start = st; bus.pause = ps; bus.cancel = cn;
    bus.digits_in = din;
    @(negedge clk);
    bus.tick = 0; bus.load = 0; bus.start = 0; bus.pause = 0; bus.cancel = 0;
  endtask

`ifdef TIMER_ADD30_EN
  task automatic drive_add(input bit tk);
    bus.add30 = 1'b1; bus.tick = tk;
    @(negedge clk);
    bus.add30 = 1'b0; bus.tick = 1'b0;
  endtask
`endif

  initial begin
    bus.tick = 0; bus.load = 0; bus.start = 0; bus.pause = 0; bus.cancel = 0;
    bus.digits_in = '0;
`ifdef TIMER_ADD30_EN
    bus.add30 = 0;
`endif
    #1 clear_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    chk_en  = 1'b1;
    expect_dig("rst_digits", 16'h0000);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd1);
    chk("rst_flags", 32'({bus.running, bus.done, bus.load_err}), 32'd0);

    drive(0, 1, 0, 0, 0, 16'h0130);
    drive(0, 0, 1, 0, 0, 16'h0000);
    chk("start_state", 32'(bus.state), 32'd1);
    drive(1, 0, 0, 0, 0, 16'h0000);
    expect_dig("tick_0129", 16'h0129);
    drive(0, 1, 0, 0, 0, 16'h0500);
    expect_dig("load_in_run", 16'h0129);

    drive(0, 0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'h0100);
    drive(0, 0, 1, 0, 0, 16'h0000);
    drive(1, 0, 0, 0, 0, 16'h0000);
    expect_dig("borrow_0059", 16'h0059);
    drive(0, 0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'h1000);
    drive(0, 0, 1, 0, 0, 16'h0000);
    drive(1, 0, 0, 0, 0, 16'h0000);
    expect_dig("borrow_0959", 16'h0959);

    drive(0, 0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'h0001);
    drive(0, 0, 1, 0, 0, 16'h0000);
    drive(1, 0, 0, 0, 0, 16'h0000);
    expect_dig("reach_zero", 16'h0000);
    chk("done_state", 32'(bus.state), 32'd3);
    chk("done_pulse", 32'(bus.done), 32'd1);
    drive(0, 0, 0, 0, 0, 16'h0000);
    chk("done_drop", 32'(bus.done), 32'd0);
    for (int k = 0; k < 5; k++) drive(1, 0, 0, 0, 0, 16'h0000);
    expect_dig("no_wrap", 16'h0000);
    drive(0, 0, 1, 0, 0, 16'h0000);
    chk("start_in_done", 32'(bus.state), 32'd3);

    drive(0, 1, 0, 0, 0, 16'h00F9);
    expect_dig("clamp_0059", 16'h0059);
    chk("load_err_pulse", 32'(bus.load_err), 32'd1);
    drive(0, 0, 1, 0, 0, 16'h0000);
    chk("load_err_drop", 32'(bus.load_err), 32'd0);
    drive(1, 0, 1, 1, 0, 16'h0000);
    chk("pause_wins", 32'(bus.state), 32'd2);
    expect_dig("pause_no_dec", 16'h0059);

    drive(0, 0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'h0245);
    drive(0, 0, 1, 0, 0, 16'h0000);
    drive(0, 0, 0, 0, 1, 16'h0000);
    expect_dig("cancel_digits", 16'h0000);
    chk("cancel_state", 32'(bus.state), 32'd0);
    drive(0, 1, 0, 0, 0, 16'h0245);
    drive(0, 0, 1, 0, 0, 16'h0000);
    #2 clear_n = 1'b0;
    #1;
    expect_dig("async_digits", 16'h0000);
    chk("async_zero", 32'(bus.zero), 32'd1);
    chk("async_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;

`ifdef TIMER_ADD30_EN
    drive_add(0);
    expect_dig("add_quick", 16'h0030);
    chk("add_quick_state", 32'(bus.state), 32'd1);
    drive(0, 0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'h0045);
    drive_add(0);
    expect_dig("add_carry", 16'h0115);
    drive(0, 1, 0, 0, 0, 16'h9959);
    drive_add(0);
    expect_dig("add_sat", 16'h9959);
`endif

    for (int n = 0; n < 4000; n++) begin
      din_r = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
      bus.digits_in = din_r;
      bus.tick   = ($urandom_range(0, 99) < 35);
      bus.load   = ($urandom_range(0, 99) < 3);
      bus.start  = ($urandom_range(0, 99) < 10);
      bus.pause  = ($urandom_range(0, 99) < 3);
      bus.cancel = ($urandom_range(0, 199) == 0);
`ifdef TIMER_ADD30_EN
      bus.add30  = ($urandom_range(0, 99) < 3);
`endif
      if ($urandom_range(0, 999) < 2) #2 clear_n = 1'b0;
      @(negedge clk);
      clear_n = 1'b1;
    end
    bus.tick = 0; bus.load = 0; bus.start = 0; bus.pause = 0; bus.cancel = 0;
`ifdef TIMER_ADD30_EN
    bus.add30 = 0;
`endif
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
